tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Four-slot time-division demultiplexer with registered, frame-atomic outputs.
- Receives a serial stream of WIDTH-bit beats, where a frame is four valid beats and the first beat is marked by frame_sync.
- Distributes slot 0..3 to ch0..ch3.
- Sits at the receive end of a 4:1 TDM link; it is the sequential counterpart to the team's 4:1 selector.

Parameters:
- WIDTH, 8, bit width of each beat and each channel output

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- din  input  WIDTH  incoming beat
- din_valid  input  1  din is a real beat this cycle; a low cycle is a gap
- frame_sync  input  1  marks din as slot 0; ignored when din_valid=0
- ch0  output  WIDTH  slot 0 of last complete frame
- ch1  output  WIDTH  slot 1 of last complete frame
- ch2  output  WIDTH  slot 2 of last complete frame
- ch3  output  WIDTH  slot 3 of last complete frame
- frame_valid  output  1  one-cycle pulse: ch0..ch3 just updated
- locked  output  1  high while in LOCKED state
- sync_err  output  1  one-cycle pulse on framing violation

Behaviour:
- Reset values:
  - clk and rst: one clock; reset is asynchronous and active-high.
  - While rst=1, ch0..ch3=0, frame_valid=0, locked=0, sync_err=0, state=HUNT, slot counter=0, shadow regs=0.
- Accepted beat: din_valid=1 at a rising edge. Gap cycles (din_valid=0) change nothing; the counter holds and no timeout applies.
- State machine (2 states):
  - HUNT:
    - Valid beat without frame_sync: discarded.
    - Valid beat with frame_sync: stored in shadow slot 0, slot counter=1, go LOCKED.
  - LOCKED, slot counter=k, k in 1..3:
    - Valid beat without frame_sync: stored in shadow slot k, counter=k+1 mod 4.
    - Valid beat with frame_sync: mid-frame violation. sync_err pulses, the partial frame is discarded, this beat becomes the new slot 0, counter=1, stay LOCKED.
  - LOCKED, counter=0 (frame boundary):
    - Valid beat with frame_sync: slot 0 of the next frame, counter=1.
    - Valid beat without frame_sync: lost alignment. sync_err pulses, beat discarded, go HUNT, counter=0.
- Output update:
  - At the edge accepting slot 3, ch0..ch2 load from shadow 0..2 and ch3 loads din directly.
  - frame_valid=1 for the cycle following that edge. Latency is 1 clock from the slot-3 beat.
  - ch outputs hold between updates and never show a partial frame.
- frame_valid and sync_err are never both high: the slot-3 beat carries no sync and therefore cannot be an error.
- locked is a registered decode of the state and goes high the cycle after the slot-0 beat is accepted in HUNT.
- Back-to-back frames with no gaps are supported: one frame per 4 clocks, with frame_valid every 4th cycle.
- Reset mid-frame: all state is cleared asynchronously. A partial frame is lost, and the outputs show 0 until the next complete frame.

Decomposition:
- Shared include tdm_defs.vh holds:
  - state encodings ST_HUNT=1'b0 and ST_LOCKED=1'b1
  - NUM_SLOTS=4
  - SLOT_W=2
- One natural sub-module, tdm_slot_ctr. It is a 2-bit counter with synchronous load-to-1 (on sync), increment-on-valid and clear, plus async rst.
- The FSM, shadow registers and output registers stay in the top module.

Test Plan:
- Clean frame: rst pulse, then beats {sync,0xA1},0xB2,0xC3,0xD4 on consecutive cycles. Required response: after the 4th edge ch0..3=A1,B2,C3,D4, frame_valid high exactly 1 cycle, locked=1, sync_err=0.
- Gaps: same frame with din_valid=0 for 3 cycles between each beat. Required response: identical outputs, one frame_valid pulse, and ch outputs held at their old values until the slot-3 beat.
- Early sync: {sync,0x11},0x22,{sync,0x33},0x44,0x55,0x66. Required response: sync_err pulse on the 3rd beat; frame output ch=33,44,55,66, with no frame containing 0x11 or 0x22.
- Lost alignment: complete frame, then valid 0x77 without sync at the boundary. Required response: sync_err pulse, locked falls, 0x77 discarded. Beats without sync in HUNT give no output change until the next sync.
- Back-to-back: 3 frames with no gaps, values 0x00..0x0B. Required response: frame_valid at cycles 4, 8 and 12; ch3 = 0x03, 0x07, 0x0B.
- Reset mid-frame: assert rst asynchronously (between edges) after slot 1 of a frame. Required response: all outputs 0 immediately and locked=0. A subsequent full frame decodes correctly.

Source files
------------

// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the four-slot TDM demultiplexer.
package tdm_demux4_pkg;

   localparam int unsigned NUM_SLOTS = 4;
   localparam int unsigned SLOT_W    = 2;

   typedef enum logic {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter: clear has priority over load-to-1, which has priority over increment.
module tdm_slot_ctr
   import tdm_demux4_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              load1_i,
   input  logic              inc_i,
   output logic [SLOT_W-1:0] cnt_o
);

   logic [SLOT_W-1:0] cnt_q;
   logic [SLOT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load1_i) begin
         cnt_d = SLOT_W'(1);
      end else if (inc_i) begin
         cnt_d = cnt_q + SLOT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer with frame-atomic registered channel outputs.
module tdm_demux4
   import tdm_demux4_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] ch0,
   output logic [WIDTH-1:0] ch1,
   output logic [WIDTH-1:0] ch2,
   output logic [WIDTH-1:0] ch3,
   output logic             frame_valid,
   output logic             locked,
   output logic             sync_err
);

   state_e            state_q, state_d;
   logic [SLOT_W-1:0] cnt;
   logic              ctr_clr, ctr_load1, ctr_inc;

   logic [WIDTH-1:0]  sh0_q, sh1_q, sh2_q;
   logic [WIDTH-1:0]  sh0_d, sh1_d, sh2_d;
   logic [WIDTH-1:0]  ch0_q, ch1_q, ch2_q, ch3_q;
   logic [WIDTH-1:0]  ch0_d, ch1_d, ch2_d, ch3_d;
   logic              fv_q, fv_d;
   logic              err_q, err_d;
   logic              locked_q;

   tdm_slot_ctr u_slot_ctr (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (ctr_clr),
      .load1_i (ctr_load1),
      .inc_i   (ctr_inc),
      .cnt_o   (cnt)
   );

   // Next-state, shadow capture and frame publish.
   always_comb begin
      state_d   = state_q;
      ctr_clr   = 1'b0;
      ctr_load1 = 1'b0;
      ctr_inc   = 1'b0;
      sh0_d     = sh0_q;
      sh1_d     = sh1_q;
      sh2_d     = sh2_q;
      ch0_d     = ch0_q;
      ch1_d     = ch1_q;
      ch2_d     = ch2_q;
      ch3_d     = ch3_q;
      fv_d      = 1'b0;
      err_d     = 1'b0;

      if (din_valid) begin
         unique case (state_q)
            ST_HUNT: begin
               if (frame_sync) begin
                  sh0_d     = din;
                  ctr_load1 = 1'b1;
                  state_d   = ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (cnt == '0) begin
                  if (frame_sync) begin
                     sh0_d     = din;
                     ctr_load1 = 1'b1;
                  end else begin
                     err_d   = 1'b1;
                     ctr_clr = 1'b1;
                     state_d = ST_HUNT;
                  end
               end else if (frame_sync) begin
                  // Mid-frame sync restarts the frame; stale shadows are overwritten later.
                  err_d     = 1'b1;
                  sh0_d     = din;
                  ctr_load1 = 1'b1;
               end else begin
                  ctr_inc = 1'b1;
                  unique case (cnt)
                     SLOT_W'(1): sh1_d = din;
                     SLOT_W'(2): sh2_d = din;
                     default: begin
                        ch0_d = sh0_q;
                        ch1_d = sh1_q;
                        ch2_d = sh2_q;
                        ch3_d = din;
                        fv_d  = 1'b1;
                     end
                  endcase
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_HUNT;
         sh0_q    <= '0;
         sh1_q    <= '0;
         sh2_q    <= '0;
         ch0_q    <= '0;
         ch1_q    <= '0;
         ch2_q    <= '0;
         ch3_q    <= '0;
         fv_q     <= 1'b0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sh0_q    <= sh0_d;
         sh1_q    <= sh1_d;
         sh2_q    <= sh2_d;
         ch0_q    <= ch0_d;
         ch1_q    <= ch1_d;
         ch2_q    <= ch2_d;
         ch3_q    <= ch3_d;
         fv_q     <= fv_d;
         err_q    <= err_d;
         locked_q <= (state_d == ST_LOCKED);
      end
   end

   assign ch0         = ch0_q;
   assign ch1         = ch1_q;
   assign ch2         = ch2_q;
   assign ch3         = ch3_q;
   assign frame_valid = fv_q;
   assign sync_err    = err_q;
   assign locked      = locked_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed table-driven bench for tdm_demux4 plus an async mid-frame reset sequence.
module tb_tdm_demux4;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic [W-1:0] din;
   logic         din_valid;
   logic         frame_sync;
   logic [W-1:0] ch0, ch1, ch2, ch3;
   logic         frame_valid, locked, sync_err;

   int total;
   int bad;

   typedef struct {
      logic         v;
      logic         s;
      logic [W-1:0] d;
      logic [W-1:0] c0, c1, c2, c3;
      logic         fv, lk, er;
   } vec_t;

   vec_t vecs[$];

   tdm_demux4 #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .frame_sync  (frame_sync),
      .ch0         (ch0),
      .ch1         (ch1),
      .ch2         (ch2),
      .ch3         (ch3),
      .frame_valid (frame_valid),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(input logic v, input logic s, input logic [W-1:0] d,
                               input logic [W-1:0] c0, input logic [W-1:0] c1,
                               input logic [W-1:0] c2, input logic [W-1:0] c3,
                               input logic fv, input logic lk, input logic er);
      vec_t r;
      r.v = v; r.s = s; r.d = d;
      r.c0 = c0; r.c1 = c1; r.c2 = c2; r.c3 = c3;
      r.fv = fv; r.lk = lk; r.er = er;
      vecs.push_back(r);
   endfunction

   task automatic check(input string name, input logic [W-1:0] c0, input logic [W-1:0] c1,
                        input logic [W-1:0] c2, input logic [W-1:0] c3,
                        input logic fv, input logic lk, input logic er);
      total++;
      if ({ch0, ch1, ch2, ch3, frame_valid, locked, sync_err} !== {c0, c1, c2, c3, fv, lk, er}) begin
         bad++;
         $display("FAIL %s: got ch=%h,%h,%h,%h fv=%b lk=%b err=%b want ch=%h,%h,%h,%h fv=%b lk=%b err=%b",
                  name, ch0, ch1, ch2, ch3, frame_valid, locked, sync_err,
                  c0, c1, c2, c3, fv, lk, er);
      end
   endtask

   task automatic beat(input logic v, input logic s, input logic [W-1:0] d);
      @(negedge clk);
      din_valid  = v;
      frame_sync = s;
      din        = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst        = 1'b1;
      din        = '0;
      din_valid  = 1'b0;
      frame_sync = 1'b0;

      // Clean frame, then one idle cycle to see the pulse end.
      add(1, 1, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0);
      add(1, 0, 8'hB2, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0);
      add(1, 0, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0);
      add(1, 0, 8'hD4, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1, 1, 0);
      add(0, 0, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 0);

      // Gapped frame: outputs hold the old frame until the slot-3 beat.
      add(1, 1, 8'h5A, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 0);
      for (int g = 0; g < 3; g++) add(0, 1, 8'hFF, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 0);
      add(1, 0, 8'h6B, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 0);
      for (int g = 0; g < 3; g++) add(0, 0, 8'hEE, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 0);
      add(1, 0, 8'h7C, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 0);
      for (int g = 0; g < 3; g++) add(0, 1, 8'hDD, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 0);
      add(1, 0, 8'h8D, 8'h5A, 8'h6B, 8'h7C, 8'h8D, 1, 1, 0);
      add(0, 0, 8'h00, 8'h5A, 8'h6B, 8'h7C, 8'h8D, 0, 1, 0);

      // Early sync on the third beat.
      add(1, 1, 8'h11, 8'h5A, 8'h6B, 8'h7C, 8'h8D, 0, 1, 0);
      add(1, 0, 8'h22, 8'h5A, 8'h6B, 8'h7C, 8'h8D, 0, 1, 0);
      add(1, 1, 8'h33, 8'h5A, 8'h6B, 8'h7C, 8'h8D, 0, 1, 1);
      add(1, 0, 8'h44, 8'h5A, 8'h6B, 8'h7C, 8'h8D, 0, 1, 0);
      add(1, 0, 8'h55, 8'h5A, 8'h6B, 8'h7C, 8'h8D, 0, 1, 0);
      add(1, 0, 8'h66, 8'h33, 8'h44, 8'h55, 8'h66, 1, 1, 0);

      // Lost alignment at the boundary, then unsynced beats in HUNT.
      add(1, 0, 8'h77, 8'h33, 8'h44, 8'h55, 8'h66, 0, 0, 1);
      add(1, 0, 8'h88, 8'h33, 8'h44, 8'h55, 8'h66, 0, 0, 0);
      add(1, 0, 8'h99, 8'h33, 8'h44, 8'h55, 8'h66, 0, 0, 0);
      add(1, 0, 8'hAA, 8'h33, 8'h44, 8'h55, 8'h66, 0, 0, 0);

      // Three back-to-back frames 0x00..0x0B.
      add(1, 1, 8'h00, 8'h33, 8'h44, 8'h55, 8'h66, 0, 1, 0);
      add(1, 0, 8'h01, 8'h33, 8'h44, 8'h55, 8'h66, 0, 1, 0);
      add(1, 0, 8'h02, 8'h33, 8'h44, 8'h55, 8'h66, 0, 1, 0);
      add(1, 0, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 1, 1, 0);
      add(1, 1, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 0, 1, 0);
      add(1, 0, 8'h05, 8'h00, 8'h01, 8'h02, 8'h03, 0, 1, 0);
      add(1, 0, 8'h06, 8'h00, 8'h01, 8'h02, 8'h03, 0, 1, 0);
      add(1, 0, 8'h07, 8'h04, 8'h05, 8'h06, 8'h07, 1, 1, 0);
      add(1, 1, 8'h08, 8'h04, 8'h05, 8'h06, 8'h07, 0, 1, 0);
      add(1, 0, 8'h09, 8'h04, 8'h05, 8'h06, 8'h07, 0, 1, 0);
      add(1, 0, 8'h0A, 8'h04, 8'h05, 8'h06, 8'h07, 0, 1, 0);
      add(1, 0, 8'h0B, 8'h08, 8'h09, 8'h0A, 8'h0B, 1, 1, 0);

      // Reset state, including a clock edge while reset is held.
      @(posedge clk);
      #1;
      check("reset", 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         beat(vecs[i].v, vecs[i].s, vecs[i].d);
         check($sformatf("vec%0d", i), vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3,
               vecs[i].fv, vecs[i].lk, vecs[i].er);
      end

      // Async reset between edges after slot 1 of a frame.
      beat(1, 1, 8'h21);
      beat(1, 0, 8'h22);
      check("pre_rst", 8'h08, 8'h09, 8'h0A, 8'h0B, 0, 1, 0);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // The partial frame must not complete: the next unsynced beats are discarded.
      beat(1, 0, 8'h23);
      beat(1, 0, 8'h24);
      check("post_rst_hunt", 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);

      beat(1, 1, 8'h31);
      check("rf_s0", 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0);
      beat(1, 0, 8'h32);
      beat(1, 0, 8'h33);
      beat(1, 0, 8'h34);
      check("rf_done", 8'h31, 8'h32, 8'h33, 8'h34, 1, 1, 0);
      beat(0, 0, 8'h00);
      check("rf_hold", 8'h31, 8'h32, 8'h33, 8'h34, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
